// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared button-FSM state type and default timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int c_CLK_HZ         = 50_000_000;
    localparam int c_DB_CYCLES      = c_CLK_HZ / 200;   // 5 ms
    localparam int c_REPEAT_DELAY   = c_CLK_HZ / 2;     // 500 ms
    localparam int c_REPEAT_PERIOD  = c_CLK_HZ / 10;    // 100 ms

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2,
        HOLD_ONLY   = 2'd3
    } btn_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_pulse_gen_debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Brief    : Two-flop synchronizer plus stable-count debouncer for btn_raw.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_filter
    import game_pkg::*;
#(
    parameter int DB_CYCLES = c_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_rise,
    output logic press_fall
);

    localparam int                  c_CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_db_cnt;

    // r_level is the filtered level; pressed lags it by one edge so the FSM
    // can act on the same edge that pressed changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
            pressed  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            pressed <= r_level;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_CNT_LAST) begin
                r_level  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign press_rise = r_level & ~pressed;
    assign press_fall = ~r_level & pressed;

endmodule
`default_nettype wire

// File: rtl/btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : btn_pulse_gen
// Brief    : Debounced push-button to single-cycle inc pulses, hold-to-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module btn_pulse_gen
    import game_pkg::*;
#(
    parameter int DB_CYCLES     = c_DB_CYCLES,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = c_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = c_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic enable,
    output logic pressed,
    output logic pulse
);

    localparam int                  c_REP_W       = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [c_REP_W-1:0]  c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0]  c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    if ((DB_CYCLES < 1) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
        $error("btn_pulse_gen: DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
    end

    logic               w_press_rise;
    logic               w_press_fall;
    logic               w_rep_done;
    logic               w_pulse_next;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_cnt_next;
    btn_state_t         r_state;
    btn_state_t         w_state_next;

    debounce_filter #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .pressed    (pressed),
        .press_rise (w_press_rise),
        .press_fall (w_press_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rep_cnt <= '0;
            pulse     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rep_cnt <= w_rep_cnt_next;
            pulse     <= w_pulse_next;
        end
    end

    assign w_rep_done = ((r_state == HOLD_DELAY)  && (r_rep_cnt == c_DELAY_LAST)) ||
                        ((r_state == HOLD_REPEAT) && (r_rep_cnt == c_PERIOD_LAST));

    always_comb begin
        w_state_next   = r_state;
        w_rep_cnt_next = '0;
        unique case (r_state)
            IDLE: begin
                if (w_press_rise) begin
                    w_state_next = REPEAT_EN ? HOLD_DELAY : HOLD_ONLY;
                end
            end
            HOLD_DELAY: begin
                if (w_press_fall) begin
                    w_state_next = IDLE;
                end else if (w_rep_done) begin
                    w_state_next = HOLD_REPEAT;
                end else begin
                    w_rep_cnt_next = r_rep_cnt + 1'b1;
                end
            end
            HOLD_REPEAT: begin
                if (w_press_fall) begin
                    w_state_next = IDLE;
                end else if (!w_rep_done) begin
                    w_rep_cnt_next = r_rep_cnt + 1'b1;
                end
            end
            HOLD_ONLY: begin
                if (w_press_fall) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Release beats a coincident timer expiry; a slot seen with enable low is lost.
    always_comb begin
        w_pulse_next = 1'b0;
        unique case (r_state)
            IDLE:                    w_pulse_next = w_press_rise & enable;
            HOLD_DELAY, HOLD_REPEAT: w_pulse_next = w_rep_done & ~w_press_fall & enable;
            default:                 w_pulse_next = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_pulse_gen
// Brief    : Self-checking bench for btn_pulse_gen against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_pulse_gen;

    localparam int c_DB  = 4;
    localparam int c_DLY = 10;
    localparam int c_PER = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic r_btn = 1'b0;
    logic r_en  = 1'b1;
    logic w_pressed_rep, w_pulse_rep;
    logic w_pressed_one, w_pulse_one;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    btn_pulse_gen #(
        .DB_CYCLES     (c_DB),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (c_DLY),
        .REPEAT_PERIOD (c_PER)
    ) u_dut_rep (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (r_btn),
        .enable  (r_en),
        .pressed (w_pressed_rep),
        .pulse   (w_pulse_rep)
    );

    btn_pulse_gen #(
        .DB_CYCLES     (c_DB),
        .REPEAT_EN     (1'b0),
        .REPEAT_DELAY  (c_DLY),
        .REPEAT_PERIOD (c_PER)
    ) u_dut_one (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (r_btn),
        .enable  (r_en),
        .pressed (w_pressed_one),
        .pulse   (w_pulse_one)
    );

    always #5 clk = ~clk;

    // Timeline model: edge index e counts edges since reset; hist[e] is btn_raw seen at edge e.
    bit hist[$];
    int e      = 0;
    bit m_lvl  = 1'b0;
    bit m_prs  = 1'b0;
    bit m_pls[2];
    bit m_held[2];
    int m_t0[2];
    int pq_rep[$];
    int pq_one[$];
    int rise_e = -1;
    int fall_e = -1;

    task automatic model_step();
        bit flip, rise, fall, s;
        int d;
        if (rst) begin
            hist.delete();
            e = 0; m_lvl = 0; m_prs = 0;
            for (int i = 0; i < 2; i++) begin m_pls[i] = 0; m_held[i] = 0; m_t0[i] = 0; end
            pq_rep.delete(); pq_one.delete();
            rise_e = -1; fall_e = -1;
            return;
        end
        rise = m_lvl && !m_prs;
        fall = !m_lvl && m_prs;
        // level flips once the input, two edges late, has disagreed with it for DB edges in a row
        flip = 1'b1;
        for (int j = 0; j < c_DB; j++) begin
            s = (e - 2 - j >= 0) ? hist[e - 2 - j] : 1'b0;
            if (s == m_lvl) flip = 1'b0;
        end
        hist.push_back(r_btn);
        m_prs = m_lvl;
        if (flip) m_lvl = !m_lvl;
        if (rise) rise_e = e;
        if (fall) fall_e = e;
        for (int i = 0; i < 2; i++) begin
            m_pls[i] = 1'b0;
            if (rise) begin
                m_held[i] = 1'b1; m_t0[i] = e; m_pls[i] = r_en;
            end else if (m_held[i] && fall) begin
                m_held[i] = 1'b0;
            end else if (m_held[i] && i == 0) begin
                d = e - m_t0[i];
                if (d == c_DLY || (d > c_DLY && (d - c_DLY) % c_PER == 0)) m_pls[i] = r_en;
            end
        end
        if (m_pls[0]) pq_rep.push_back(e);
        if (m_pls[1]) pq_one.push_back(e);
        e++;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic cmp(input string nm, input logic prs, input logic pls, input bit eprs, input bit epls);
        n_vec++;
        if (prs !== eprs || pls !== epls) begin
            n_bad++;
            $display("FAIL %s @%0t: pressed=%b pulse=%b, want pressed=%b pulse=%b",
                     nm, $time, prs, pls, eprs, epls);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            cmp("cycle rep", w_pressed_rep, w_pulse_rep, m_prs, m_pls[0]);
            cmp("cycle one", w_pressed_one, w_pulse_one, m_prs, m_pls[1]);
        end
    end

    task automatic pin_q(input string nm, input int act[$], input int exp[$]);
        bit ok;
        ok = (act.size() == exp.size());
        if (ok) foreach (exp[j]) if (act[j] != exp[j]) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %p, want %p", nm, act, exp);
        end
    endtask

    task automatic pin_i(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input bit b, input bit en);
        r_btn = b;
        r_en  = en;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        r_btn = 1'b0;
        r_en  = 1'b1;
        rst   = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst   = 1'b0;
    endtask

    initial begin
        int q[$];
        int len;
        bit b;

        do_reset();
        chk_on = 1'b1;
        pin_i("reset pressed", int'(w_pressed_rep), 0);
        pin_i("reset pulse", int'(w_pulse_rep), 0);

        // Clean hold
        for (int k = 0; k < 50; k++) step(k < 30, 1'b1);
        q = '{6, 16, 19, 22, 25, 28, 31, 34};
        pin_q("hold repeat pulses", pq_rep, q);
        q = '{6};
        pin_q("hold single pulse", pq_one, q);
        pin_i("hold rise edge", rise_e, 6);
        pin_i("hold fall edge", fall_e, 36);

        // Bounce reject
        do_reset();
        for (int k = 0; k < 40; k++) step((k < 20) && ((k / 2) % 2 == 0), 1'b1);
        pin_i("bounce pulses", pq_rep.size(), 0);
        pin_i("bounce rise", rise_e, -1);

        // Short press
        do_reset();
        for (int k = 0; k < 30; k++) step(k < 8, 1'b1);
        q = '{6};
        pin_q("short pulses", pq_rep, q);
        pin_i("short fall edge", fall_e, 14);

        // Enable gating
        do_reset();
        for (int k = 0; k < 50; k++) step(k < 30, k >= 18);
        q = '{19, 22, 25, 28, 31, 34};
        pin_q("gated pulses", pq_rep, q);
        pin_i("gated single", pq_one.size(), 0);
        pin_i("gated rise edge", rise_e, 6);
        pin_i("gated fall edge", fall_e, 36);

        // Reset mid-repeat, button still held
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1);
        pin_i("pre-reset pressed", int'(w_pressed_rep), 1);
        rst = 1'b1;
        #1;
        pin_i("async reset pressed", int'(w_pressed_rep | w_pressed_one), 0);
        pin_i("async reset pulse", int'(w_pulse_rep | w_pulse_one), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 50; k++) step(k < 30, 1'b1);
        q = '{6, 16, 19, 22, 25, 28, 31, 34};
        pin_q("post-reset pulses", pq_rep, q);

        // Single-shot variant held long
        do_reset();
        for (int k = 0; k < 60; k++) step(k < 40, 1'b1);
        q = '{6};
        pin_q("no-repeat pulses", pq_one, q);

        // Random segments
        do_reset();
        for (int s = 0; s < 70; s++) begin
            len = $urandom_range(1, 25);
            b   = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) step(b, $urandom_range(0, 5) != 0);
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
